// File: rtl/testbasic20_types.sv
// Shared types for the testbasic20 sections: the compound word carried on b_out
// and the state encoding of the output-channel arbiter.
package testbasic20_types;

    typedef enum logic {
        read  = 1'b0,
        write = 1'b1
    } ModeType;

    typedef struct packed {
        ModeType    mode;
        logic [7:0] x;
        logic [7:0] y;
    } CompoundType;

    localparam CompoundType COMPOUND_RESET = '{mode: read, x: 8'd0, y: 8'd0};

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_SEND = 1'b1
    } arb_section_t;

endpackage

// File: rtl/compound_rr_pick.sv
// Round-robin pick: first eligible index scanning upward from last_grant+1,
// wrapping modulo NUM_REQ.
module compound_rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [IDX_W-1:0]   sel,
    output logic               any
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;

    always_comb begin
        // NOTE: every output and temporary gets a default first, so no path leaves a latch.
        sel = last_grant;
        any = 1'b0;
        sum = '0;
        idx = '0;
        // Scan from the farthest offset down so the nearest eligible index wins last.
        for (int k = NUM_REQ; k >= 1; k--) begin
            sum = {1'b0, last_grant} + (IDX_W + 1)'(k);
            if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
                sum = sum - (IDX_W + 1)'(NUM_REQ);
            end
            idx = sum[IDX_W-1:0];
            if (eligible[idx]) begin
                sel = idx;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/compound_out_arbiter.sv
// Shares the single blocking CompoundType output channel among NUM_REQ producers:
// captures one word per notify/sync handshake and re-offers it on b_out.
module compound_out_arbiter
    import testbasic20_types::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int CNT_W   = 16,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  CompoundType         req_data [NUM_REQ],
    input  logic [NUM_REQ-1:0]  req_notify,
    output logic [NUM_REQ-1:0]  req_sync,
    output CompoundType         b_out,
    output logic                b_out_notify,
    input  logic                b_out_sync,
    output logic [IDX_W-1:0]    grant_id,
    output logic [CNT_W-1:0]    xfer_count
);

    arb_section_t       section;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   sel;
    logic               any;
    logic               xfer;
    logic               load;
    logic [NUM_REQ-1:0] eligible;

    // A requester still seeing its sync pulse has already been captured.
    assign eligible     = req_notify & ~req_sync;
    assign b_out_notify = (section == ARB_SEND);
    assign xfer         = b_out_notify && b_out_sync;
    assign load         = (section == ARB_IDLE) || xfer;

    compound_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .eligible   (eligible),
        .last_grant (last_grant),
        .sel        (sel),
        .any        (any)
    );

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register reading pre-edge values.
        if (!rst) begin
            section    <= ARB_IDLE;
            req_sync   <= '0;
            b_out      <= COMPOUND_RESET;
            grant_id   <= '0;
            last_grant <= IDX_W'(NUM_REQ - 1);
            xfer_count <= '0;
        end else begin
            req_sync <= '0;
            if (xfer) begin
                xfer_count <= xfer_count + CNT_W'(1);
            end
            if (load) begin
                if (any) begin
                    b_out      <= req_data[sel];
                    grant_id   <= sel;
                    last_grant <= sel;
                    req_sync   <= NUM_REQ'(1) << sel;
                    section    <= ARB_SEND;
                end else begin
                    section <= ARB_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_compound_out_arbiter.sv
// Randomized bench for compound_out_arbiter with a transaction-level model and
// directed checks of reset, stall, rotation, masking and counter wrap.
module tb_compound_out_arbiter;
    import testbasic20_types::*;

    localparam int N  = 4;
    localparam int CW = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    CompoundType   req_data [N];
    logic [N-1:0]  req_notify;
    logic [N-1:0]  req_sync;
    CompoundType   b_out;
    logic          b_out_notify;
    logic          b_out_sync;
    logic [IW-1:0] grant_id;
    logic [CW-1:0] xfer_count;

    always #5 clk = ~clk;

    compound_out_arbiter #(.NUM_REQ(N), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_data     (req_data),
        .req_notify   (req_notify),
        .req_sync     (req_sync),
        .b_out        (b_out),
        .b_out_notify (b_out_notify),
        .b_out_sync   (b_out_sync),
        .grant_id     (grant_id),
        .xfer_count   (xfer_count)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;
    logic [N-1:0] seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic CompoundType rand_word();
        CompoundType w;
        w.mode = ModeType'($urandom_range(1));
        w.x    = 8'($urandom);
        w.y    = 8'($urandom);
        return w;
    endfunction

    // Model of the channel: is a word held, which word, from whom, who pulses sync.
    bit           m_valid;
    CompoundType  m_word;
    int           m_gid;
    int           m_last;
    int           m_count;
    logic [N-1:0] m_sync;

    function automatic int rr_pick(input logic [N-1:0] elig, input int last);
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (last + k) % N;
            if (elig[IW'(j)]) return j;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        bit           xfer;
        int           s;
        logic [N-1:0] nxt;
        if (!rst) begin
            m_valid = 1'b0;
            m_word  = COMPOUND_RESET;
            m_gid   = 0;
            m_last  = N - 1;
            m_count = 0;
            m_sync  = '0;
        end else begin
            xfer = m_valid && b_out_sync;
            if (xfer) m_count = (m_count + 1) % (1 << CW);
            nxt = '0;
            if (!m_valid || xfer) begin
                s = rr_pick(req_notify & ~m_sync, m_last);
                if (s >= 0) begin
                    m_word   = req_data[s];
                    m_gid    = s;
                    m_last   = s;
                    nxt[s]   = 1'b1;
                    m_valid  = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end
            end
            m_sync = nxt;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_notify", b_out_notify, m_valid);
            check("m_b_out",  b_out,        m_word);
            check("m_grant",  grant_id,     m_gid);
            check("m_sync",   req_sync,     m_sync);
            check("m_count",  xfer_count,   m_count);
        end
    end

    // Requesters: hold until sync seen, then change in the following cycle.
    task automatic auto_step(input int act_pct);
        for (int i = 0; i < N; i++) begin
            if (seen[i] || !req_notify[i]) begin
                if (int'($urandom_range(99)) < act_pct) begin
                    req_notify[i] = 1'b1;
                    req_data[i]   = rand_word();
                end else begin
                    req_notify[i] = 1'b0;
                end
            end
            seen[i] = req_sync[i];
        end
    endtask

    initial begin
        CompoundType exp_w;
        CompoundType held;
        int          act_pct;
        int          sync_pct;

        rst        = 1'b0;
        req_notify = '0;
        b_out_sync = 1'b0;
        seen       = '0;
        for (int i = 0; i < N; i++) req_data[i] = COMPOUND_RESET;

        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_notify", b_out_notify, 1'b0);
        check("rst_b_out",  b_out,        17'd0);
        check("rst_grant",  grant_id,     2'd0);
        check("rst_sync",   req_sync,     4'b0000);
        check("rst_count",  xfer_count,   4'd0);
        rst = 1'b1;

        // Requester 2 alone, consumer stalled.
        exp_w           = '{mode: write, x: 8'd5, y: 8'd1};
        req_data[2]     = exp_w;
        req_notify[2]   = 1'b1;
        @(negedge clk);
        check("r2_b_out",  b_out,        {1'b1, 8'd5, 8'd1});
        check("r2_notify", b_out_notify, 1'b1);
        check("r2_sync",   req_sync,     4'b0100);
        check("r2_grant",  grant_id,     2'd2);
        auto_step(0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("stall_b_out",  b_out,        {1'b1, 8'd5, 8'd1});
            check("stall_grant",  grant_id,     2'd2);
            check("stall_notify", b_out_notify, 1'b1);
            check("stall_sync",   req_sync,     4'b0000);
            auto_step(0);
        end
        b_out_sync = 1'b1;
        @(negedge clk);
        check("r2_done_notify", b_out_notify, 1'b0);
        check("r2_done_count",  xfer_count,   4'd1);
        auto_step(0);

        // Requester 1 alone; transfer lands on its sync cycle.
        req_data[1]   = rand_word();
        held          = req_data[1];
        req_notify[1] = 1'b1;
        @(negedge clk);
        check("r1_sync",  req_sync, 4'b0010);
        check("r1_b_out", b_out,    held);
        auto_step(0);
        @(negedge clk);
        check("r1_idle",  b_out_notify, 1'b0);
        check("r1_count", xfer_count,   4'd2);
        auto_step(0);
        @(negedge clk);
        check("r1_nodup", b_out_notify, 1'b0);
        check("r1_count2", xfer_count,  4'd2);
        b_out_sync = 1'b0;

        // Reset while holding a word.
        req_data[1]   = rand_word();
        req_notify[1] = 1'b1;
        @(negedge clk);
        check("pre_rst_notify", b_out_notify, 1'b1);
        auto_step(0);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_notify", b_out_notify, 1'b0);
        check("mid_rst_count",  xfer_count,   4'd0);
        check("mid_rst_b_out",  b_out,        17'd0);
        rst = 1'b1;

        // All requesters active, consumer always ready: strict rotation from 0.
        for (int i = 0; i < N; i++) begin
            req_notify[i] = 1'b1;
            req_data[i]   = rand_word();
        end
        seen       = '0;
        b_out_sync = 1'b1;
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            check("rot_grant",  grant_id,     32'(k % N));
            check("rot_notify", b_out_notify, 1'b1);
            if (k == 5) check("rot_count5", xfer_count, 4'd5);
            auto_step(100);
        end
        @(negedge clk);
        check("wrap_count", xfer_count, 4'd1);

        // Random traffic with occasional resets.
        act_pct  = 50;
        sync_pct = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0) begin
                act_pct  = int'($urandom_range(100));
                sync_pct = 10 + int'($urandom_range(90));
            end
            b_out_sync = (int'($urandom_range(99)) < sync_pct);
            rst        = ($urandom_range(299) != 0);
            auto_step(act_pct);
            @(negedge clk);
        end

        rst        = 1'b1;
        b_out_sync = 1'b0;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
